meta_flush_engine: RTL and testbench

Sequential scanner that walks the L1 valid/dirty metadata arrays on a flush request and drives write-back requests for every valid-and-dirty set. After each write-back completes, it clears the set's dirty bit through the metadata array's load port. It sits beside the L1 cache controller, which owns the metadata arrays and muxes this block's index and load signals onto them while `busy` is high. The metadata arrays are written by the cache controller; this block is their bulk reader and clearer.

---
 rtl/meta_flush_engine_if.sv | 31 +++
 rtl/meta_flush_engine.sv | 88 ++++++++
 tb/tb_meta_flush_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/meta_flush_engine_if.sv
// rtl/meta_flush_engine_if.sv - flush request, metadata array and write-back signals of the flush engine
interface meta_flush_engine_if #(
    parameter int s_index = 4
);
    logic               flush_req;
    logic               busy;
    logic               flush_done;
    logic [s_index-1:0] meta_index;
    logic               valid_in;
    logic               dirty_in;
    logic               dirty_load;
    logic               dirty_datain;
    logic               valid_load;
    logic               valid_datain;
    logic               wb_req;
    logic [s_index-1:0] wb_index;
    logic               wb_ack;

    // master: the flush engine; slave: the cache controller / memory side
    modport master (
        input  flush_req, valid_in, dirty_in, wb_ack,
        output busy, flush_done, meta_index, dirty_load, dirty_datain,
               valid_load, valid_datain, wb_req, wb_index
    );

    modport slave (
        output flush_req, valid_in, dirty_in, wb_ack,
        input  busy, flush_done, meta_index, dirty_load, dirty_datain,
               valid_load, valid_datain, wb_req, wb_index
    );
endinterface

// File: rtl/meta_flush_engine.sv
// rtl/meta_flush_engine.sv - walks L1 valid/dirty metadata, writes back and clears dirty sets
// Optional FLUSH_INVALIDATE_EN: also clears every valid bit during the scan.
module meta_flush_engine #(
    parameter int s_index = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    meta_flush_engine_if.master  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SCAN  = 3'd1;
    localparam logic [2:0] WB    = 3'd2;
    localparam logic [2:0] CLEAR = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [s_index-1:0] last_idx = {s_index{1'b1}};
    localparam logic [s_index-1:0] one_idx  = {{(s_index-1){1'b0}}, 1'b1};

    logic [2:0]         state;
    logic [s_index-1:0] idx;
    logic               hit;

    // array read data is combinational at meta_index, so the SCAN decision is same-cycle
    assign hit = bus.valid_in & bus.dirty_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush_req) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state <= WB;
                    end else if (idx == last_idx) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + one_idx;
                    end
                end
                WB: begin
                    if (bus.wb_ack) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (idx == last_idx) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + one_idx;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.flush_done   = (state == DONE);
    assign bus.meta_index   = idx;
    assign bus.wb_req       = (state == WB);
    assign bus.wb_index     = idx;
    assign bus.dirty_load   = (state == CLEAR);
    assign bus.dirty_datain = 1'b0;
    assign bus.valid_datain = 1'b0;

`ifdef FLUSH_INVALIDATE_EN
    // clean sets are invalidated as they are scanned, dirty sets once written back
    assign bus.valid_load = (state == CLEAR) | ((state == SCAN) & ~hit);
`else
    assign bus.valid_load = 1'b0;
`endif

endmodule

// File: tb/tb_meta_flush_engine.sv
// tb/tb_meta_flush_engine.sv - randomized bench for meta_flush_engine against a set-level cost model
module tb_meta_flush_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meta_flush_engine_if #(.s_index(4)) bus ();
    meta_flush_engine #(.s_index(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    bit [15:0] valid_arr, dirty_arr;
    int        k_arr[16];
    assign bus.valid_in = valid_arr[bus.meta_index];
    assign bus.dirty_in = dirty_arr[bus.meta_index];

    int checks = 0;
    int errors = 0;
    int cyc;

    int wb_q[$], dl_q[$], vl_q[$], meta_q[$], done_q[$];
    int busy_after;
    bit aborted;
    logic [14:0] post_vec;

    int exp_wb_q[$], exp_dl_q[$], exp_vl_q[$];
    int exp_done;
    bit [15:0] exp_valid, exp_dirty;

    function automatic bit q_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input int a[$]);
        string s = "";
        foreach (a[i]) s = {s, $sformatf("%0d ", a[i])};
        return s;
    endfunction

    // each set costs 1 cycle if not valid&dirty, else 3+k; done follows the last set
    task automatic build_expect();
        int c = 0;
        exp_wb_q.delete(); exp_dl_q.delete(); exp_vl_q.delete();
        for (int s = 0; s < 16; s++) begin
            if (valid_arr[s] && dirty_arr[s]) begin
                c += 3 + k_arr[s];
                repeat (k_arr[s] + 1) exp_wb_q.push_back(s);
                exp_dl_q.push_back(s);
            end else begin
                c += 1;
            end
`ifdef FLUSH_INVALIDATE_EN
            exp_vl_q.push_back(s);
`endif
        end
        exp_done  = c + 1;
        exp_dirty = dirty_arr & ~valid_arr;
`ifdef FLUSH_INVALIDATE_EN
        exp_valid = 16'h0000;
`else
        exp_valid = valid_arr;
`endif
    endtask

    task automatic run_flush(input bit stray, input int abort_set);
        int  wb_j = 0;
        int  last_wb = -1;
        bit  pend_d = 0, pend_v = 0;
        bit  pend_dv = 0, pend_vv = 0;
        int  pend_idx = 0;
        wb_q.delete(); dl_q.delete(); vl_q.delete(); meta_q.delete(); done_q.delete();
        busy_after = -1;
        aborted = 0;
        cyc = 0;
        bus.flush_req = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            if (pend_d) dirty_arr[pend_idx] = pend_dv;
            if (pend_v) valid_arr[pend_idx] = pend_vv;
            pend_d = 0;
            pend_v = 0;
            #1;
            cyc++;
            if (bus.wb_req) begin
                if (last_wb == int'(bus.wb_index)) wb_j++;
                else wb_j = 0;
                last_wb = int'(bus.wb_index);
            end else begin
                last_wb = -1;
            end
            bus.flush_req = (stray && bus.busy && !bus.flush_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.wb_req) bus.wb_ack = (wb_j == k_arr[bus.wb_index]);
            else bus.wb_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            if (abort_set >= 0 && bus.wb_req && int'(bus.wb_index) == abort_set && wb_j == 1)
                rst = 1'b1;
            @(negedge clk);
            meta_q.push_back(int'(bus.meta_index));
            if (bus.wb_req) wb_q.push_back(int'(bus.wb_index));
            if (bus.dirty_load) begin
                dl_q.push_back(int'(bus.meta_index));
                pend_d = 1; pend_dv = bus.dirty_datain; pend_idx = int'(bus.meta_index);
            end
            if (bus.valid_load) begin
                vl_q.push_back(int'(bus.meta_index));
                pend_v = 1; pend_vv = bus.valid_datain; pend_idx = int'(bus.meta_index);
            end
            if (bus.flush_done) done_q.push_back(cyc);
            if (rst) begin
                @(posedge clk);
                @(negedge clk);
                post_vec = {bus.busy, bus.flush_done, bus.meta_index, bus.dirty_load,
                            bus.valid_load, bus.wb_req, bus.wb_index, bus.flush_done};
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (done_q.size() > 0 && cyc == done_q[0] + 1) begin
                busy_after = int'(bus.busy);
                break;
            end
        end
        bus.flush_req = 1'b0;
        bus.wb_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_req = 1'b1;
        bus.wb_ack = 1'b1;
        valid_arr = 16'hffff;
        dirty_arr = 16'hffff;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %0b expected 0", bus.flush_done); end
        checks++; if (bus.meta_index !== 4'd0) begin errors++; $display("FAIL reset_meta_index: got %0d expected 0", bus.meta_index); end
        checks++; if ({bus.dirty_load, bus.valid_load} !== 2'b00) begin errors++; $display("FAIL reset_loads: got %b expected 00", {bus.dirty_load, bus.valid_load}); end
        checks++; if ({bus.wb_req, bus.wb_index} !== 5'd0) begin errors++; $display("FAIL reset_wb: got %b expected 00000", {bus.wb_req, bus.wb_index}); end
        checks++; if ({bus.dirty_datain, bus.valid_datain} !== 2'b00) begin errors++; $display("FAIL reset_datain: got %b expected 00", {bus.dirty_datain, bus.valid_datain}); end
        bus.flush_req = 1'b0;
        bus.wb_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_clean();
        bit seq_ok = 1;
        valid_arr = 16'($urandom);
        dirty_arr = 16'h0000;
        foreach (k_arr[i]) k_arr[i] = 0;
        build_expect();
        run_flush(0, -1);
        for (int c = 1; c <= 16; c++) if (meta_q.size() < c || meta_q[c-1] != c - 1) seq_ok = 0;
        checks++; if (!seq_ok) begin errors++; $display("FAIL clean_meta_seq: got %s expected 0..15", q_str(meta_q)); end
        checks++; if (done_q.size() != 1 || done_q[0] != 17) begin errors++; $display("FAIL clean_done_cycle: got %s expected 17", q_str(done_q)); end
        checks++; if (wb_q.size() != 0) begin errors++; $display("FAIL clean_no_wb: got %0d wb cycles expected 0", wb_q.size()); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL clean_busy_after: got %0d expected 0", busy_after); end
        checks++; if (!q_eq(vl_q, exp_vl_q)) begin errors++; $display("FAIL clean_valid_load: got %s expected %s", q_str(vl_q), q_str(exp_vl_q)); end
    endtask

    task automatic test_single_dirty();
        valid_arr = 16'($urandom) | 16'h0020;
        dirty_arr = 16'h0020;
        foreach (k_arr[i]) k_arr[i] = 0;
        build_expect();
        run_flush(0, -1);
        checks++; if (!q_eq(wb_q, exp_wb_q)) begin errors++; $display("FAIL single_wb: got %s expected %s", q_str(wb_q), q_str(exp_wb_q)); end
        checks++; if (!q_eq(dl_q, exp_dl_q)) begin errors++; $display("FAIL single_dirty_load: got %s expected %s", q_str(dl_q), q_str(exp_dl_q)); end
        checks++; if (done_q.size() != 1 || done_q[0] != 19) begin errors++; $display("FAIL single_done_cycle: got %s expected 19", q_str(done_q)); end
        checks++; if (dirty_arr[5] !== 1'b0) begin errors++; $display("FAIL single_dirty5_cleared: got %0b expected 0", dirty_arr[5]); end
    endtask

    task automatic test_two_dirty_delayed();
        valid_arr = 16'($urandom) | 16'h8001;
        dirty_arr = 16'h8001;
        foreach (k_arr[i]) k_arr[i] = 4;
        build_expect();
        run_flush(0, -1);
        checks++; if (!q_eq(wb_q, exp_wb_q)) begin errors++; $display("FAIL two_wb_stable: got %s expected %s", q_str(wb_q), q_str(exp_wb_q)); end
        checks++; if (!q_eq(dl_q, exp_dl_q)) begin errors++; $display("FAIL two_dirty_load: got %s expected %s", q_str(dl_q), q_str(exp_dl_q)); end
        checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("FAIL two_done_cycle: got %s expected %0d", q_str(done_q), exp_done); end
        checks++; if (dirty_arr !== exp_dirty) begin errors++; $display("FAIL two_dirty_final: got %h expected %h", dirty_arr, exp_dirty); end
    endtask

    task automatic test_invalid_dirty();
        valid_arr = 16'($urandom) & ~16'h0008;
        dirty_arr = 16'h0008;
        foreach (k_arr[i]) k_arr[i] = 0;
        build_expect();
        run_flush(0, -1);
        checks++; if (wb_q.size() != 0) begin errors++; $display("FAIL invdirty_no_wb: got %s expected none", q_str(wb_q)); end
        checks++; if (dirty_arr[3] !== 1'b1) begin errors++; $display("FAIL invdirty_dirty3_kept: got %0b expected 1", dirty_arr[3]); end
        checks++; if (!q_eq(vl_q, exp_vl_q)) begin errors++; $display("FAIL invdirty_valid_load: got %s expected %s", q_str(vl_q), q_str(exp_vl_q)); end
        checks++; if (valid_arr !== exp_valid) begin errors++; $display("FAIL invdirty_valid_final: got %h expected %h", valid_arr, exp_valid); end
    endtask

    task automatic test_reset_in_wb();
        valid_arr = 16'($urandom) | 16'h0080;
        dirty_arr = 16'h0080;
        foreach (k_arr[i]) k_arr[i] = 10;
        run_flush(0, 7);
        checks++; if (!aborted) begin errors++; $display("FAIL rstwb_reached: got 0 expected 1"); end
        checks++; if (post_vec !== 15'd0) begin errors++; $display("FAIL rstwb_outputs_zero: got %b expected 0", post_vec); end
        checks++; if (dirty_arr[7] !== 1'b1) begin errors++; $display("FAIL rstwb_dirty7_kept: got %0b expected 1", dirty_arr[7]); end
        foreach (k_arr[i]) k_arr[i] = 1;
        build_expect();
        run_flush(0, -1);
        checks++; if (meta_q.size() == 0 || meta_q[0] != 0) begin errors++; $display("FAIL rstwb_restart_idx: got %s expected 0 first", q_str(meta_q)); end
        checks++; if (!q_eq(wb_q, exp_wb_q)) begin errors++; $display("FAIL rstwb_restart_wb: got %s expected %s", q_str(wb_q), q_str(exp_wb_q)); end
        checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("FAIL rstwb_restart_done: got %s expected %0d", q_str(done_q), exp_done); end
    endtask

    task automatic test_stray_inputs();
        for (int it = 0; it < 3; it++) begin
            valid_arr = 16'($urandom);
            dirty_arr = 16'($urandom);
            foreach (k_arr[i]) k_arr[i] = $urandom_range(0, 2);
            build_expect();
            run_flush(1, -1);
            checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("FAIL stray_done_%0d: got %s expected %0d", it, q_str(done_q), exp_done); end
            checks++; if (!q_eq(wb_q, exp_wb_q)) begin errors++; $display("FAIL stray_wb_%0d: got %s expected %s", it, q_str(wb_q), q_str(exp_wb_q)); end
            checks++; if (dirty_arr !== exp_dirty) begin errors++; $display("FAIL stray_dirty_%0d: got %h expected %h", it, dirty_arr, exp_dirty); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            valid_arr = 16'($urandom);
            dirty_arr = 16'($urandom);
            foreach (k_arr[i]) k_arr[i] = $urandom_range(0, 2);
            build_expect();
            run_flush(0, -1);
            checks++; if (done_q.size() != 1 || done_q[0] != exp_done) begin errors++; $display("FAIL rand_done_%0d: got %s expected %0d", it, q_str(done_q), exp_done); end
            checks++; if (!q_eq(wb_q, exp_wb_q)) begin errors++; $display("FAIL rand_wb_%0d: got %s expected %s", it, q_str(wb_q), q_str(exp_wb_q)); end
            checks++; if (!q_eq(dl_q, exp_dl_q)) begin errors++; $display("FAIL rand_dl_%0d: got %s expected %s", it, q_str(dl_q), q_str(exp_dl_q)); end
            checks++; if (!q_eq(vl_q, exp_vl_q)) begin errors++; $display("FAIL rand_vl_%0d: got %s expected %s", it, q_str(vl_q), q_str(exp_vl_q)); end
            checks++; if (dirty_arr !== exp_dirty || valid_arr !== exp_valid) begin errors++; $display("FAIL rand_arrays_%0d: got %h/%h expected %h/%h", it, valid_arr, dirty_arr, exp_valid, exp_dirty); end
        end
    endtask

    initial begin
        bus.flush_req = 1'b0;
        bus.wb_ack = 1'b0;
        rst = 1'b1;
        valid_arr = '0;
        dirty_arr = '0;
        foreach (k_arr[i]) k_arr[i] = 0;
        test_reset();
        test_all_clean();
        test_single_dirty();
        test_two_dirty_delayed();
        test_invalid_dirty();
        test_reset_in_wb();
        test_stray_inputs();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
